systolic_feeder: RTL and testbench

- Transmit side of the PE edge interface: buffers one N×N A tile and one N×N B tile, then drives skewed operand streams into the west and north edges of an N×N systolic PE array.
- Also issues the per-tile accumulator clear and signals completion once the final products have settled in the array.
- Sits between the tile loader (memory/DMA side) and the PE grid.

---
 rtl/systolic_feeder.sv | 156 +++++++++++++++
 tb/tb_systolic_feeder.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/systolic_feeder.sv
// systolic_feeder: buffers one NxN A tile and one NxN B tile from the tile
// loader, then streams them diagonally skewed into the west and north edges
// of an NxN systolic PE array. It also issues the per-tile accumulator clear
// and pulses done once the last products have settled.
module systolic_feeder #(
    parameter int WIDTH        = 16,
    parameter int N            = 4,
    parameter int DRAIN_CYCLES = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [N*WIDTH-1:0]   in_a,
    input  logic [N*WIDTH-1:0]   in_b,
    output logic [N*WIDTH-1:0]   out_west,
    output logic [N*WIDTH-1:0]   out_north,
    output logic                 feed_valid,
    output logic                 pe_clear,
    output logic                 busy,
    output logic                 done
);

    // k indexes one reduction step, t spans the whole skewed feed window
    localparam int KW = (N > 1) ? $clog2(N) : 1;
    localparam int TW = $clog2(3 * N);
    localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [TW-1:0] T_LAST = TW'(3 * N - 3);

    typedef enum logic [2:0] {
        S_LOAD,
        S_CLEAR,
        S_FEED,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t          state_reg;
    logic [KW-1:0]   k_reg;
    logic [TW-1:0]   t_reg;
    logic [DW-1:0]   d_reg;

    // a_buf[i][k] = A[i][k], b_buf[k][j] = B[k][j]
    logic [WIDTH-1:0] a_buf [N][N];
    logic [WIDTH-1:0] b_buf [N][N];

    logic               beat;
    logic               feed_next;
    logic [TW-1:0]      t_next;
    logic [N*WIDTH-1:0] west_next;
    logic [N*WIDTH-1:0] north_next;

    assign in_ready = (state_reg == S_LOAD);
    assign busy     = (state_reg != S_LOAD);
    assign beat     = in_valid && in_ready;

    // Which feed slot the output registers will show in the next cycle
    always_comb begin
        feed_next = 1'b0;
        t_next    = '0;
        if (state_reg == S_CLEAR) begin
            feed_next = 1'b1;
        end else if (state_reg == S_FEED && t_reg != T_LAST) begin
            feed_next = 1'b1;
            t_next    = t_reg + TW'(1);
        end
    end

    // Lane gi is delayed by gi cycles; outside its N-cycle window it carries 0
    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_lane
            logic [TW-1:0] off;
            logic          in_win;
            assign off    = t_next - TW'(gi);
            assign in_win = (t_next >= TW'(gi)) && (off < TW'(N));
            assign west_next[gi*WIDTH +: WIDTH]  = in_win ? a_buf[gi][off[KW-1:0]] : '0;
            assign north_next[gi*WIDTH +: WIDTH] = in_win ? b_buf[off[KW-1:0]][gi] : '0;
        end
    endgenerate

    // Capture a load beat: in_a is column k of A, in_b is row k of B
    always_ff @(posedge clk) begin
        if (beat && !rst) begin
            for (int i = 0; i < N; i++) begin
                a_buf[i][k_reg] <= in_a[i*WIDTH +: WIDTH];
                b_buf[k_reg][i] <= in_b[i*WIDTH +: WIDTH];
            end
        end
    end

    // Tile sequencer with registered stream and control outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= S_LOAD;
            k_reg      <= '0;
            t_reg      <= '0;
            d_reg      <= '0;
            out_west   <= '0;
            out_north  <= '0;
            feed_valid <= 1'b0;
            pe_clear   <= 1'b0;
            done       <= 1'b0;
        end else begin
            pe_clear   <= 1'b0;
            done       <= 1'b0;
            feed_valid <= feed_next;
            out_west   <= feed_next ? west_next  : '0;
            out_north  <= feed_next ? north_next : '0;
            case (state_reg)
                S_LOAD: begin
                    if (beat) begin
                        if (k_reg == KW'(N - 1)) begin
                            k_reg     <= '0;
                            state_reg <= S_CLEAR;
                            pe_clear  <= 1'b1;
                        end else begin
                            k_reg <= k_reg + KW'(1);
                        end
                    end
                end
                S_CLEAR: begin
                    t_reg     <= '0;
                    state_reg <= S_FEED;
                end
                S_FEED: begin
                    if (t_reg == T_LAST) begin
                        d_reg <= '0;
                        if (DRAIN_CYCLES == 0) begin
                            state_reg <= S_DONE;
                            done      <= 1'b1;
                        end else begin
                            state_reg <= S_DRAIN;
                        end
                    end else begin
                        t_reg <= t_next;
                    end
                end
                S_DRAIN: begin
                    if (d_reg == DW'(DRAIN_CYCLES - 1)) begin
                        state_reg <= S_DONE;
                        done      <= 1'b1;
                    end else begin
                        d_reg <= d_reg + DW'(1);
                    end
                end
                S_DONE: begin
                    state_reg <= S_LOAD;
                end
                default: begin
                    state_reg <= S_LOAD;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_systolic_feeder.sv
// Scoreboard bench for systolic_feeder: the driver loads tiles and pushes the
// expected skewed feed schedule; the monitor pops and compares on every
// feed_valid cycle and checks clear/done timing.
module tb_systolic_feeder;

    localparam int W   = 16;
    localparam int N   = 4;
    localparam int DR  = 2;
    localparam int NT  = 3 * N - 2;
    localparam int LAT = 1 + NT + DR;
    localparam int PERIOD = N + 1 + NT + DR + 1;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           in_valid = 1'b0;
    logic           in_ready;
    logic [N*W-1:0] in_a = '0;
    logic [N*W-1:0] in_b = '0;
    logic [N*W-1:0] out_west;
    logic [N*W-1:0] out_north;
    logic           feed_valid;
    logic           pe_clear;
    logic           busy;
    logic           done;

    systolic_feeder #(.WIDTH(W), .N(N), .DRAIN_CYCLES(DR)) dut (
        .clk(clk),
        .rst(rst),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_a(in_a),
        .in_b(in_b),
        .out_west(out_west),
        .out_north(out_north),
        .feed_valid(feed_valid),
        .pe_clear(pe_clear),
        .busy(busy),
        .done(done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        logic [N*W-1:0] w;
        logic [N*W-1:0] n;
    } feed_t;

    feed_t feed_q[$];
    int    clr_q[$];
    int    n_cmp = 0;
    int    n_err = 0;
    int    last_clear = 0;
    bit    done_pending = 0;
    int    tiles_done = 0;
    feed_t e;

    logic [W-1:0] ma [N][N];
    logic [W-1:0] mb [N][N];
    bit pat [7] = '{1, 0, 0, 1, 1, 0, 1};

    // Reference: scatter every operand to the slot it must appear in
    task automatic push_model();
        feed_t sched [NT];
        for (int t = 0; t < NT; t++) sched[t] = '0;
        for (int i = 0; i < N; i++)
            for (int k = 0; k < N; k++)
                sched[k+i].w[i*W +: W] = ma[i][k];
        for (int k = 0; k < N; k++)
            for (int j = 0; j < N; j++)
                sched[k+j].n[j*W +: W] = mb[k][j];
        for (int t = 0; t < NT; t++) feed_q.push_back(sched[t]);
    endtask

    // Monitor: compare outputs just after each rising edge
    always @(posedge clk) begin
        #1;
        if (rst) begin
            n_cmp++;
            if (out_west != '0 || out_north != '0 || feed_valid || pe_clear || done || busy || !in_ready) begin
                n_err++;
                $display("FAIL reset_state: west=%h north=%h fv=%b clr=%b done=%b busy=%b ready=%b required zeros, ready=1",
                         out_west, out_north, feed_valid, pe_clear, done, busy, in_ready);
            end
            feed_q.delete();
            clr_q.delete();
            done_pending = 0;
        end else begin
            n_cmp++;
            if (in_ready !== !busy) begin
                n_err++;
                $display("FAIL ready_busy: ready=%b busy=%b required complementary", in_ready, busy);
            end
            if (feed_valid) begin
                n_cmp++;
                if (feed_q.size() == 0) begin
                    n_err++;
                    $display("FAIL feed_unexpected: feed_valid=1 at cycle %0d required 0", cyc);
                end else begin
                    e = feed_q.pop_front();
                    if (out_west !== e.w || out_north !== e.n) begin
                        n_err++;
                        $display("FAIL feed_data: west=%h north=%h required west=%h north=%h",
                                 out_west, out_north, e.w, e.n);
                    end
                end
            end else begin
                n_cmp++;
                if (out_west != '0 || out_north != '0) begin
                    n_err++;
                    $display("FAIL idle_bus: west=%h north=%h required 0", out_west, out_north);
                end
            end
            if (pe_clear) begin
                n_cmp++;
                if (clr_q.size() == 0) begin
                    n_err++;
                    $display("FAIL clear_unexpected: pe_clear=1 at cycle %0d required 0", cyc);
                end else if (cyc != clr_q[0]) begin
                    n_err++;
                    $display("FAIL clear_cycle: cycle=%0d required %0d", cyc, clr_q[0]);
                end
                if (clr_q.size() != 0) void'(clr_q.pop_front());
                last_clear   = cyc;
                done_pending = 1;
            end
            if (done) begin
                n_cmp++;
                if (!done_pending || (cyc - last_clear) != LAT || feed_q.size() != 0) begin
                    n_err++;
                    $display("FAIL done_timing: pending=%0b latency=%0d left=%0d required pending=1 latency=%0d left=0",
                             done_pending, cyc - last_clear, feed_q.size(), LAT);
                end
                done_pending = 0;
                tiles_done++;
                $display("tile %0d done at cycle %0d (clear at %0d)", tiles_done, cyc, last_clear);
            end
        end
    end

    task automatic rand_tile();
        for (int i = 0; i < N; i++)
            for (int k = 0; k < N; k++) begin
                ma[i][k] = W'($urandom);
                mb[i][k] = W'($urandom);
            end
    endtask

    task automatic load_tile(input bit gaps, input bit junk, output int first_cyc);
        int k = 0;
        int p = 0;
        bit v;
        first_cyc = 0;
        while (k < N) begin
            @(negedge clk);
            v = gaps ? pat[p % 7] : 1'b1;
            p++;
            in_valid = v;
            for (int l = 0; l < N; l++) begin
                in_a[l*W +: W] = v ? ma[l][k] : W'($urandom);
                in_b[l*W +: W] = v ? mb[k][l] : W'($urandom);
            end
            if (v) begin
                n_cmp++;
                if (in_ready !== 1'b1) begin
                    n_err++;
                    $display("FAIL ready_load: in_ready=%b at beat %0d required 1", in_ready, k);
                end
                if (k == 0) first_cyc = cyc;
                if (k == N - 1) begin
                    push_model();
                    clr_q.push_back(cyc + 1);
                end
                k++;
            end
        end
        @(negedge clk);
        in_valid = junk;
        in_a = {$urandom, $urandom};
        in_b = {$urandom, $urandom};
    endtask

    task automatic wait_done(input bit junk);
        bit seen = 0;
        for (int c = 0; c < 64 && !seen; c++) begin
            @(negedge clk);
            if (junk) begin
                n_cmp++;
                if (in_ready !== 1'b0) begin
                    n_err++;
                    $display("FAIL ready_busy_hold: in_ready=%b required 0", in_ready);
                end
                in_a = {$urandom, $urandom};
                in_b = {$urandom, $urandom};
            end
            if (done) begin
                seen = 1;
                in_valid = 1'b0;
            end
        end
        if (!seen) begin
            n_cmp++;
            n_err++;
            in_valid = 1'b0;
            $display("FAIL done_timeout: done=0 after 64 cycles required 1");
        end
    endtask

    task automatic wait_feed(input int beats);
        int cnt = 0;
        for (int c = 0; c < 64 && cnt < beats; c++) begin
            @(negedge clk);
            if (feed_valid) cnt++;
        end
        if (cnt < beats) begin
            n_cmp++;
            n_err++;
            $display("FAIL feed_timeout: saw %0d feed cycles required %0d", cnt, beats);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int f0, f1, f2;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);

        // Identity x ramp, one beat per cycle
        for (int i = 0; i < N; i++)
            for (int k = 0; k < N; k++) begin
                ma[i][k] = (i == k) ? 16'h0100 : 16'h0000;
                mb[i][k] = W'(256 * (N * i + k + 1));
            end
        load_tile(1'b0, 1'b0, f0);
        wait_done(1'b0);

        // Gapped load with a negative operand, in_valid held high while busy
        rand_tile();
        ma[3][3] = 16'hFF80;
        load_tile(1'b1, 1'b1, f0);
        wait_done(1'b1);

        // Abort with reset at feed slot t=4
        rand_tile();
        load_tile(1'b0, 1'b0, f0);
        wait_feed(5);
        rst = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;

        // Fresh tile, then a back-to-back tile starting right after done
        rand_tile();
        load_tile(1'b0, 1'b0, f1);
        wait_done(1'b0);
        rand_tile();
        load_tile(1'b0, 1'b0, f2);
        n_cmp++;
        if (f2 - f1 != PERIOD) begin
            n_err++;
            $display("FAIL tile_period: period=%0d required %0d", f2 - f1, PERIOD);
        end
        wait_done(1'b0);

        rand_tile();
        load_tile(1'b1, 1'b0, f0);
        wait_done(1'b0);

        repeat (5) @(negedge clk);
        n_cmp++;
        if (tiles_done != 5 || feed_q.size() != 0 || clr_q.size() != 0) begin
            n_err++;
            $display("FAIL final_scoreboard: tiles=%0d feed_left=%0d clr_left=%0d required 5/0/0",
                     tiles_done, feed_q.size(), clr_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
